// File: rtl/asmd_divider_pkg.sv
// Shared constants and state encoding for the restoring shift-subtract divider.
// Imported by the interface, the control unit, the datapath and the top.
package asmd_divider_pkg;

    localparam int WORD_LENGTH = 4;
    localparam int CNT_W       = $clog2(WORD_LENGTH + 1);

    typedef enum logic {
        s_idle    = 1'b0,
        s_running = 1'b1
    } state_e;

endpackage

// File: rtl/asmd_divider_if.sv
// Request/response bundle between a divider client (master) and the divider (slave).
// Handshake: a request is accepted on the rising edge where start=1 and ready=1;
// start while ready=0 is dropped, and results are valid whenever ready=1.
interface asmd_divider_if
    import asmd_divider_pkg::*;
#(
    parameter int W = WORD_LENGTH
);
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         start;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         ready;
    logic         div_by_zero;

    modport master (
        output dividend, divisor, start,
        input  quotient, remainder, ready, div_by_zero
    );

    modport slave (
        input  dividend, divisor, start,
        output quotient, remainder, ready, div_by_zero
    );
endinterface

// File: rtl/divider_control_unit.sv
// ASMD control unit: idle/running state register and the strobes that steer the datapath.
// ready is combinational so it drops the moment reset is asserted.
module divider_control_unit
    import asmd_divider_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start_i,
    input  logic   last_step_i,
    input  logic   dividend_zero_i,
    input  logic   divisor_zero_i,
    output logic   flush_o,
    output logic   load_words_o,
    output logic   iterate_o,
    output logic   finish_o,
    output logic   zero_div_o,
    output logic   ready_o,
    output state_e state_o
);
    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= s_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_o      = 1'b0;
        load_words_o = 1'b0;
        iterate_o    = 1'b0;
        finish_o     = 1'b0;
        zero_div_o   = 1'b0;
        case (state_q)
            s_idle: begin
                // A zero divisor wins over a zero dividend: 0/0 reports the error.
                if (start_i) begin
                    if (divisor_zero_i) begin
                        zero_div_o = 1'b1;
                    end else if (dividend_zero_i) begin
                        flush_o = 1'b1;
                    end else begin
                        load_words_o = 1'b1;
                        state_d      = s_running;
                    end
                end
            end
            s_running: begin
                iterate_o = 1'b1;
                if (last_step_i) begin
                    finish_o = 1'b1;
                    state_d  = s_idle;
                end
            end
            default: state_d = s_idle;
        endcase
    end

    assign ready_o = (state_q == s_idle) && !reset;
    assign state_o = state_q;

endmodule

// File: rtl/divider_datapath_unit.sv
// Restoring divider datapath: working registers, trial subtractor and result registers.
// One quotient bit is produced per iterate strobe, MSB first.
module divider_datapath_unit
    import asmd_divider_pkg::*;
#(
    parameter int W = WORD_LENGTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    input  logic         flush_i,
    input  logic         load_words_i,
    input  logic         iterate_i,
    input  logic         finish_i,
    input  logic         zero_div_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o,
    output logic         div_by_zero_o,
    output logic         last_step_o,
    output logic         dividend_zero_o,
    output logic         divisor_zero_o
);
    localparam int CW = $clog2(W + 1);

    logic [W:0]   rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] quotient_q, quotient_d;
    logic [W-1:0] remainder_q, remainder_d;
    logic         dbz_q, dbz_d;

    logic [W:0]   rem_shift;
    logic [W+1:0] trial;
    logic         borrow;
    logic [W:0]   rem_step;
    logic [W-1:0] quo_step;

    // The partial remainder stays below the divisor, so rem_q[W] is zero here;
    // it still feeds the subtractor so the full register takes part in the compare.
    assign rem_shift = {rem_q[W-1:0], quo_q[W-1]};
    assign trial     = {rem_q, quo_q[W-1]} - {2'b00, dvs_q};
    assign borrow    = trial[W+1];
    assign rem_step  = borrow ? rem_shift : trial[W:0];
    assign quo_step  = {quo_q[W-2:0], ~borrow};

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (zero_div_i) begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
        end
        if (flush_i) begin
            quotient_d  = '0;
            remainder_d = '0;
            dbz_d       = 1'b0;
        end
        if (load_words_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = CW'(W);
            dbz_d = 1'b0;
        end
        if (iterate_i) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CW'(1);
        end
        if (finish_i) begin
            quotient_d  = quo_step;
            remainder_d = rem_step[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient_o      = quotient_q;
    assign remainder_o     = remainder_q;
    assign div_by_zero_o   = dbz_q;
    assign last_step_o     = (cnt_q == CW'(1));
    assign dividend_zero_o = (dividend_i == '0);
    assign divisor_zero_o  = (divisor_i == '0);

endmodule

// File: rtl/asmd_divider.sv
// Sequential unsigned divider: control unit plus datapath behind the divider interface.
// Produces one quotient bit per clock; zero divisor and zero dividend finish in one edge.
module asmd_divider
    import asmd_divider_pkg::*;
#(
    parameter int W = WORD_LENGTH
) (
    input  logic           clk,
    input  logic           reset,
    asmd_divider_if.slave  bus,
    output state_e         dbg_state_o
);
    logic flush;
    logic load_words;
    logic iterate;
    logic finish;
    logic zero_div;
    logic last_step;
    logic dividend_zero;
    logic divisor_zero;
    logic ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic div_by_zero;

    divider_control_unit u_ctrl (
        .clk             (clk),
        .reset           (reset),
        .start_i         (bus.start),
        .last_step_i     (last_step),
        .dividend_zero_i (dividend_zero),
        .divisor_zero_i  (divisor_zero),
        .flush_o         (flush),
        .load_words_o    (load_words),
        .iterate_o       (iterate),
        .finish_o        (finish),
        .zero_div_o      (zero_div),
        .ready_o         (ready),
        .state_o         (dbg_state_o)
    );

    divider_datapath_unit #(.W(W)) u_dp (
        .clk             (clk),
        .reset           (reset),
        .dividend_i      (bus.dividend),
        .divisor_i       (bus.divisor),
        .flush_i         (flush),
        .load_words_i    (load_words),
        .iterate_i       (iterate),
        .finish_i        (finish),
        .zero_div_i      (zero_div),
        .quotient_o      (quotient),
        .remainder_o     (remainder),
        .div_by_zero_o   (div_by_zero),
        .last_step_o     (last_step),
        .dividend_zero_o (dividend_zero),
        .divisor_zero_o  (divisor_zero)
    );

    assign bus.ready       = ready;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;

endmodule
